// File: rtl/poly_driver_if.sv
// Operand-loading bus between a host, the poly_driver initiator and the polynomial evaluator.
// POLY_DRIVER_CHECK_EN adds the Mismatch output carried alongside Done.
interface poly_driver_if;
    logic       Start;
    logic [7:0] OpA;
    logic [7:0] OpB;
    logic [7:0] OpC;
    logic [7:0] OpX;
    logic       Busy;
    logic       Go;
    logic [7:0] DataIn;
    logic       ResultValid;
    logic [7:0] DataResult;
    logic [7:0] Result;
    logic       Done;
    logic       Error;
`ifdef POLY_DRIVER_CHECK_EN
    logic       Mismatch;

    modport master (
        input  Start, OpA, OpB, OpC, OpX, ResultValid, DataResult,
        output Busy, Go, DataIn, Result, Done, Error, Mismatch
    );

    modport slave (
        output Start, OpA, OpB, OpC, OpX, ResultValid, DataResult,
        input  Busy, Go, DataIn, Result, Done, Error, Mismatch
    );
`else
    modport master (
        input  Start, OpA, OpB, OpC, OpX, ResultValid, DataResult,
        output Busy, Go, DataIn, Result, Done, Error
    );

    modport slave (
        output Start, OpA, OpB, OpC, OpX, ResultValid, DataResult,
        input  Busy, Go, DataIn, Result, Done, Error
    );
`endif
endinterface

// File: rtl/poly_driver.sv
// Drives the evaluator's Go/DataIn sequence for operands A, B, C, X and returns its result.
// Define POLY_DRIVER_CHECK_EN to add a registered Mismatch check against an internal model.
module poly_driver #(
    parameter int HOLD_CYCLES    = 2,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          Clock,
    input  logic          Reset,
    poly_driver_if.master bus
);

    localparam int MAX_COUNT = (HOLD_CYCLES > GAP_CYCLES)
                             ? ((HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES)
                             : ((GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES);
    localparam int CW = $clog2(MAX_COUNT + 1);

    typedef enum logic [2:0] {IDLE, SETUP, PRESS, RELEASE, WAIT_RES} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [1:0]    idx, idx_next;
    logic [7:0]    ops [4];
    logic [7:0]    ops_next [4];
    logic          go, go_next;
    logic [7:0]    data_in, data_next;
    logic          busy, busy_next;
    logic [7:0]    result, result_next;
    logic          done, done_next;
    logic          error, error_next;

    assign bus.Busy   = busy;
    assign bus.Go     = go;
    assign bus.DataIn = data_in;
    assign bus.Result = result;
    assign bus.Done   = done;
    assign bus.Error  = error;

    // DataIn is loaded as SETUP is entered, so it is already stable a full cycle before Go rises.
    // A Start coinciding with a Done/Error pulse is dropped; it is taken next cycle if still held.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt + CW'(1);
        idx_next    = idx;
        ops_next    = ops;
        data_next   = data_in;
        result_next = result;
        done_next   = 1'b0;
        error_next  = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (bus.Start && !done && !error) begin
                    ops_next   = '{bus.OpA, bus.OpB, bus.OpC, bus.OpX};
                    idx_next   = 2'd0;
                    data_next  = bus.OpA;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                cnt_next   = '0;
                state_next = PRESS;
            end
            PRESS: begin
                if (cnt == CW'(HOLD_CYCLES - 1)) begin
                    cnt_next   = '0;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (cnt == CW'(GAP_CYCLES - 1)) begin
                    cnt_next = '0;
                    if (idx != 2'd3) begin
                        idx_next   = idx + 2'd1;
                        data_next  = ops[idx + 2'd1];
                        state_next = SETUP;
                    end else begin
                        state_next = WAIT_RES;
                    end
                end
            end
            WAIT_RES: begin
                if (bus.ResultValid) begin
                    result_next = bus.DataResult;
                    done_next   = 1'b1;
                    state_next  = IDLE;
                end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    error_next = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        go_next   = (state_next == PRESS);
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            ops     <= '{default: '0};
            go      <= 1'b0;
            data_in <= '0;
            busy    <= 1'b0;
            result  <= '0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            idx     <= idx_next;
            ops     <= ops_next;
            go      <= go_next;
            data_in <= data_next;
            busy    <= busy_next;
            result  <= result_next;
            done    <= done_next;
            error   <= error_next;
        end
    end

`ifdef POLY_DRIVER_CHECK_EN
    logic [7:0] model_val;
    logic       mismatch;

    // 8-bit arithmetic gives the mod-256 reduction for free.
    assign model_val    = ops[0] * ops[3] * ops[3] + ops[1] * ops[3] + ops[2];
    assign bus.Mismatch = mismatch;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            mismatch <= 1'b0;
        end else begin
            mismatch <= (state == WAIT_RES) && bus.ResultValid && (bus.DataResult != model_val);
        end
    end
`endif

endmodule
